// File: rtl/nth_root_pkg.sv
// nth_root_pkg: shared state encoding, default widths and width helper for the n-th root engine
package nth_root_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, POW, CMP, DONE} state_t;
   localparam int INT_W_DEF  = 10;
   localparam int FRAC_W_DEF = 10;
   localparam int EXP_W_DEF  = 3;
   function automatic int calc_rw(input int int_w, input int frac_w);
      return int_w + frac_w;
   endfunction
endpackage

// File: rtl/nth_root_mul_step.sv
// nth_root_mul_step: one truncating fixed-point multiply of the running power with overflow detect
module nth_root_mul_step #(
   parameter int RW     = 20,
   parameter int FRAC_W = 10
) (
   input  logic [RW-1:0] p,
   input  logic [RW-1:0] c,
   input  logic [RW-1:0] limit,
   output logic [RW-1:0] prod,
   output logic          over
);
   logic [2*RW-1:0] full;
   logic [2*RW-1:0] shifted;
   assign full    = {{RW{1'b0}}, p} * {{RW{1'b0}}, c};
   assign shifted = full >> FRAC_W;
   assign prod    = shifted[RW-1:0];
   assign over    = shifted > {{RW{1'b0}}, limit};
endmodule

// File: rtl/nth_root_unit.sv
// nth_root_unit: bit-serial fixed-point n-th root with valid/ready input and one-cycle result pulse
module nth_root_unit
   import nth_root_pkg::*;
#(
   parameter int INT_W  = INT_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF,
   parameter int EXP_W  = EXP_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [INT_W-1:0]        in_data_1,
   input  logic [EXP_W-1:0]        in_data_2,
   output logic                    out_valid,
   output logic [INT_W+FRAC_W-1:0] out_data,
   output logic                    out_exact,
   output logic                    out_err
);
   localparam int RW = calc_rw(INT_W, FRAC_W);
   localparam logic [RW-1:0] TOP_BIT = {1'b1, {(RW-1){1'b0}}};
   state_t state_q, state_d;
   logic alive_q;
   logic [INT_W-1:0] x_q, x_d;
   logic [EXP_W-1:0] n_q, n_d, cnt_q, cnt_d;
   logic [RW-1:0] mask_q, mask_d, racc_q, racc_d, p_q, p_d;
   logic over_q, over_d, exact_q, exact_d, err_q, err_d;
   logic ov_q, ov_d, oex_q, oex_d, oerr_q, oerr_d;
   logic [RW-1:0] od_q, od_d;
   logic [RW-1:0] limit, cand, prod, racc_acc, next_mask;
   logic step_over, accept;
   assign limit     = {x_q, {FRAC_W{1'b0}}};
   assign cand      = racc_q | mask_q;
   assign accept    = !over_q && (p_q <= limit);
   assign racc_acc  = accept ? cand : racc_q;
   assign next_mask = mask_q >> 1;
   assign in_ready  = alive_q && (state_q == IDLE);
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_exact = oex_q;
   assign out_err   = oerr_q;
   nth_root_mul_step #(.RW(RW), .FRAC_W(FRAC_W)) u_step (
      .p     (p_q),
      .c     (cand),
      .limit (limit),
      .prod  (prod),
      .over  (step_over)
   );
   // next-state logic: capture, load, repeated multiply, compare/accept, and result staging
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
      racc_d    = racc_q;
      p_d       = p_q;
      over_d    = over_q;
      exact_d   = exact_q;
      err_d     = err_q;
      ov_d      = state_q == DONE;
      od_d      = ov_d ? racc_q : '0;
      oex_d     = ov_d && exact_q;
      oerr_d    = ov_d && err_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               x_d     = in_data_1;
               n_d     = in_data_2;
               state_d = LOAD;
            end
         end
         LOAD: begin
            err_d   = n_q == '0;
            exact_d = n_q == EXP_W'(1);
            racc_d  = (n_q == EXP_W'(1)) ? limit : '0;
            mask_d  = TOP_BIT;
            p_d     = TOP_BIT;
            cnt_d   = '0;
            over_d  = 1'b0;
            state_d = (n_q < EXP_W'(2)) ? DONE : POW;
         end
         POW: begin
            p_d    = prod;
            cnt_d  = cnt_q + 1'b1;
            over_d = step_over;
            if (step_over || cnt_d == n_q - 1'b1) state_d = CMP;
         end
         CMP: begin
            racc_d = racc_acc;
            if (accept) exact_d = p_q == limit;
            mask_d  = next_mask;
            p_d     = racc_acc | next_mask;
            cnt_d   = '0;
            over_d  = 1'b0;
            state_d = mask_q[0] ? DONE : POW;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; reset discards any computation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         alive_q <= 1'b0;
         x_q     <= '0;
         n_q     <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         racc_q  <= '0;
         p_q     <= '0;
         over_q  <= 1'b0;
         exact_q <= 1'b0;
         err_q   <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         oex_q   <= 1'b0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         alive_q <= 1'b1;
         x_q     <= x_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         racc_q  <= racc_d;
         p_q     <= p_d;
         over_q  <= over_d;
         exact_q <= exact_d;
         err_q   <= err_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         oex_q   <= oex_d;
         oerr_q  <= oerr_d;
      end
   end
endmodule
